reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Power-up and recovery reset controller for the board-level clock domain. It waits for PLL lock, then releases three downstream reset stages in order (e.g. capture logic, SDRAM controller, CameraLink receiver). Each stage has a programmable delay and an optional ready acknowledge with timeout. It re-runs the whole sequence on PLL lock loss or a software reset request, and reports progress and faults to the status logic.

## Interface
Parameters:
- CNT_W, 24 — width of the shared delay/timeout counter.
- DLY0, 24'h1FFFFF — cycles from sequence start to oRST_0 release; must be ≥1 and < 2^CNT_W.
- DLY1, 24'h100000 — cycles from stage-0 completion to oRST_1 release; same range rule as DLY0.
- DLY2, 24'hC00000 — cycles from stage-1 completion to oRST_2 release; same range rule as DLY0.
- TIMEOUT, 24'hFFFFFF — maximum cycles to wait for a required acknowledge; must be ≥1.
- ACK_EN, 3'b111 — bit n set means stage n requires iACK[n] before the next stage proceeds.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous, active-high reset.
- iLOCK  in  1  PLL lock, asynchronous to iCLK; synchronized internally with 2 flops.
- iSOFT_RST  in  1  synchronous single-cycle request to restart the sequence.
- iACK  in  3  per-stage ready, asynchronous; each bit synchronized internally with 2 flops.
- oRST_0, oRST_1, oRST_2  out  1 each  stage reset outputs; 0 = held in reset, 1 = released.
- oSTAGE  out  2  index of the stage currently being sequenced (0..2).
- oDONE  out  1  high while in RUN.
- oFAULT  out  1  high while in FAULT.

## Operation
- States: WAIT_LOCK, DELAY, WAIT_ACK, RUN, FAULT. Internal registers are stage index n (2 bits) and cnt (CNT_W bits).
- **iRST=1:** state=WAIT_LOCK, n=0, cnt=0, all oRST_x=0, oDONE=0, oFAULT=0, sync flops=0. All outputs are registered.
- **WAIT_LOCK:** all oRST_x=0, cnt=0, n=0. When synced lock=1, go to DELAY.
- **DELAY:** cnt increments each cycle. In the cycle where cnt==DLYn-1:
  - oRST_n is set to 1 and cnt is cleared.
  - If ACK_EN[n]=1, go to WAIT_ACK.
  - Otherwise, the stage completes immediately.
- **WAIT_ACK:** cnt increments each cycle.
  - Synced iACK[n]=1 completes the stage.
  - Otherwise, when cnt==TIMEOUT-1, go to FAULT.
  - Ack takes priority over timeout in the same cycle.
- **Stage completion:** if n<2, then n increments, cnt=0, and the state goes to DELAY. If n==2, go to RUN.
- **RUN:** all oRST_x=1, oDONE=1. The acknowledges are no longer monitored.
- **FAULT:** all oRST_x=0, oFAULT=1. Lock loss does not leave FAULT. Only iSOFT_RST or iRST leaves FAULT.
- **Restart:** in any state, synced lock=0 or iSOFT_RST=1 causes the following on the next edge:
  - all oRST_x=0, oDONE=0, oFAULT=0, n=0, cnt=0;
  - state goes to WAIT_LOCK.
  - Exception: lock loss while in FAULT is ignored.
- **Priority:** iSOFT_RST and lock loss > stage completion/timeout > counting.
- **Output monotonicity:** oRST_x outputs only rise in stage order and fall together.
- **Counter:** cnt never wraps. It is cleared on every state change.
- **oSTAGE:** equals n. It reads 0 in WAIT_LOCK, RUN holds 2.

## Timing
- Let E0 be the first iCLK edge sampling iLOCK=1. Synced lock is high after E1, and the state is DELAY after E2.
- oRST_0 rises after edge E2+DLY0.
- With no ack required: oRST_1 rises DLY1 cycles after oRST_0, and oRST_2 rises DLY2 cycles after oRST_1.
- With an ack required: take the first edge sampling iACK[n]=1. Stage completion (state=DELAY) happens 2 edges later; the next release follows DLY(n+1) cycles after that.
- oDONE rises on the same edge as stage 2 completes.
- FAULT is entered exactly TIMEOUT cycles after the corresponding oRST_n rise if no ack arrives.
- Restart latency:
  - iSOFT_RST: outputs low 1 edge after the request is sampled.
  - Raw lock drop: outputs low 3 edges after it is sampled low (2 sync + 1).
- Asynchronous iRST assertion clears all outputs immediately, without waiting for a clock edge.

## Test plan
Common parameters: DLY0=4, DLY1=6, DLY2=8, TIMEOUT=16, ACK_EN=3'b010, CNT_W=8.
- **Nominal:** raise iLOCK at E0, and assert iACK[1] 3 cycles after oRST_1.
  - oRST_0 rises at E6.
  - oRST_1 rises at E12.
  - oRST_2 rises 5+8 cycles after oRST_1.
  - oDONE rises with oRST_2.
  - oSTAGE steps 0→1→2.
- **Ack timeout:** never assert iACK[1] → oFAULT=1 exactly 16 cycles after oRST_1 rises, with all oRST_x=0. A subsequent iLOCK drop leaves oFAULT at 1. Then pulse iSOFT_RST → WAIT_LOCK, and the sequence re-runs with oRST_0 at +1+4 cycles.
- **Lock loss mid-sequence:** drop iLOCK during stage-1 DELAY → all oRST_x=0 3 edges later. Restore iLOCK → full sequence repeats with identical spacing.
- **Soft reset in RUN:** pulse iSOFT_RST → oDONE=0 and all oRST_x=0 on the next edge; re-release proceeds with oRST_0 4 cycles after entering DELAY.
- **Async reset:** assert iRST between clock edges during WAIT_ACK → all outputs 0 immediately. Releasing iRST with iLOCK already high → oRST_0 rises 2+4 edges later.
- **Ack/timeout coincidence:** synced iACK[1] arrives in the same cycle where cnt==15 → stage completes, no FAULT.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-up / recovery reset sequencer: waits for PLL lock, then releases three
// reset stages in order with programmable delays and optional ack/timeout.
module reset_sequencer #(
  parameter int                CNT_W   = 24,
  parameter logic [CNT_W-1:0]  DLY0    = 24'h1FFFFF,
  parameter logic [CNT_W-1:0]  DLY1    = 24'h100000,
  parameter logic [CNT_W-1:0]  DLY2    = 24'hC00000,
  parameter logic [CNT_W-1:0]  TIMEOUT = 24'hFFFFFF,
  parameter logic [2:0]        ACK_EN  = 3'b111
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iLOCK,
  input  logic       iSOFT_RST,
  input  logic [2:0] iACK,
  output logic       oRST_0,
  output logic       oRST_1,
  output logic       oRST_2,
  output logic [1:0] oSTAGE,
  output logic       oDONE,
  output logic       oFAULT
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_DELAY,
    S_WAIT_ACK,
    S_RUN,
    S_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rst_q, rst_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic             lock_meta_q, lock_sync_q;
  logic [2:0]       ack_meta_q, ack_sync_q;

  logic [CNT_W-1:0] dly_sel;
  logic             ack_req;
  logic             ack_cur;
  logic             restart;
  logic             stage_done;

  // Two-flop synchronizers for the asynchronous lock and ack inputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      ack_meta_q  <= '0;
      ack_sync_q  <= '0;
    end else begin
      lock_meta_q <= iLOCK;
      lock_sync_q <= lock_meta_q;
      ack_meta_q  <= iACK;
      ack_sync_q  <= ack_meta_q;
    end
  end

  // State register; outputs are registered alongside it
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_WAIT_LOCK;
      n_q     <= '0;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    dly_sel = DLY2;
    ack_req = ACK_EN[2];
    ack_cur = ack_sync_q[2];
    case (n_q)
      2'd0: begin dly_sel = DLY0; ack_req = ACK_EN[0]; ack_cur = ack_sync_q[0]; end
      2'd1: begin dly_sel = DLY1; ack_req = ACK_EN[1]; ack_cur = ack_sync_q[1]; end
      default: ;
    endcase
  end

  // A latched fault survives lock loss; only a soft or hard reset clears it
  assign restart = iSOFT_RST | (~lock_sync_q & (state_q != S_FAULT));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    stage_done = 1'b0;
    if (restart) begin
      state_d = S_WAIT_LOCK;
      n_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          n_d   = '0;
          cnt_d = '0;
          if (lock_sync_q) state_d = S_DELAY;
        end
        S_DELAY: begin
          if (cnt_q == dly_sel - ONE) begin
            cnt_d = '0;
            if (ack_req) state_d = S_WAIT_ACK;
            else         stage_done = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        S_WAIT_ACK: begin
          if (ack_cur) begin
            stage_done = 1'b1;
          end else if (cnt_q == TIMEOUT - ONE) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: cnt_d = '0;
      endcase
      if (stage_done) begin
        cnt_d = '0;
        if (n_q == 2'd2) begin
          state_d = S_RUN;
        end else begin
          n_d     = n_q + 2'd1;
          state_d = S_DELAY;
        end
      end
    end
  end

  // Released bits follow the next stage index, so they only ever rise in order
  always_comb begin
    rst_d   = '0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      S_DELAY:    for (int i = 0; i < 3; i++) rst_d[i] = (i < int'(n_d));
      S_WAIT_ACK: for (int i = 0; i < 3; i++) rst_d[i] = (i <= int'(n_d));
      S_RUN: begin
        rst_d  = '1;
        done_d = 1'b1;
      end
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  assign oRST_0 = rst_q[0];
  assign oRST_1 = rst_q[1];
  assign oRST_2 = rst_q[2];
  assign oSTAGE = n_q;
  assign oDONE  = done_q;
  assign oFAULT = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with randomized ack/lock timing
// checked every cycle against an event-time model of the release schedule.
module tb_reset_sequencer;

  localparam int         CNT_W = 8;
  localparam int         D0    = 4;
  localparam int         D1    = 6;
  localparam int         D2    = 8;
  localparam int         TO    = 16;
  localparam logic [2:0] AEN   = 3'b010;
  localparam int         NEVER = 1000000;

  logic       iCLK = 1'b0;
  logic       iRST, iLOCK, iSOFT_RST;
  logic [2:0] iACK;
  logic       oRST_0, oRST_1, oRST_2, oDONE, oFAULT;
  logic [1:0] oSTAGE;

  reset_sequencer #(
    .CNT_W(CNT_W), .DLY0(8'(D0)), .DLY1(8'(D1)), .DLY2(8'(D2)),
    .TIMEOUT(8'(TO)), .ACK_EN(AEN)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iLOCK(iLOCK), .iSOFT_RST(iSOFT_RST), .iACK(iACK),
    .oRST_0(oRST_0), .oRST_1(oRST_1), .oRST_2(oRST_2),
    .oSTAGE(oSTAGE), .oDONE(oDONE), .oFAULT(oFAULT)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [2:0] rst;
    logic [1:0] stage;
    logic       done;
    logic       fault;
  } obs_t;

  int nchk = 0;
  int nerr = 0;
  int edges = 0;
  int e0;
  int ack_at [3];

  always @(posedge iCLK) edges <= edges + 1;

  function automatic int dly(int s);
    case (s)
      0:       return D0;
      1:       return D1;
      default: return D2;
    endcase
  endfunction

  // Expected outputs k edges after E0 (first edge sampling lock high), from
  // release/completion times: stage s releases DLYs after the previous
  // completion; an acked stage completes 2 edges after the ack is sampled
  // (not before the edge after release) or faults TIMEOUT edges after release.
  function automatic obs_t model(int k);
    obs_t o;
    int   t;
    int   c;
    o = '0;
    t = 2;
    for (int s = 0; s < 3; s++) begin
      o.stage = 2'(s);
      t += dly(s);
      if (k < t) return o;
      o.rst[s] = 1'b1;
      if (AEN[s]) begin
        c = (ack_at[s] + 2 > t + 1) ? ack_at[s] + 2 : t + 1;
        if (c > t + TO) begin
          if (k >= t + TO) begin
            o.rst   = '0;
            o.fault = 1'b1;
          end
          return o;
        end
        if (k < c) return o;
        t = c;
      end
    end
    o.done = 1'b1;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.rst   = {oRST_2, oRST_1, oRST_0};
    o.stage = oSTAGE;
    o.done  = oDONE;
    o.fault = oFAULT;
    return o;
  endfunction

  task automatic check(obs_t exp, string tag);
    obs_t got;
    got = cur();
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got rst=%b stage=%0d done=%b fault=%b, expected rst=%b stage=%0d done=%b fault=%b",
             tag, got.rst, got.stage, got.done, got.fault, exp.rst, exp.stage, exp.done, exp.fault);
    end
  endtask

  // Step cycle by cycle from the current E0 up to stop_k, raising iACK[1]
  // so that it is first sampled ack_rel edges after oRST_1 is due.
  task automatic run_seq(int ack_rel, int stop_k, string tag);
    int k;
    ack_at[0] = NEVER;
    ack_at[2] = NEVER;
    ack_at[1] = (ack_rel > 900) ? NEVER : 2 + D0 + D1 + ack_rel;
    k = edges - e0;
    while (k < stop_k) begin
      @(negedge iCLK);
      k = edges - e0;
      check(model(k), $sformatf("%s k=%0d", tag, k));
      if (k == ack_at[1] - 1) iACK[1] = 1'b1;
    end
  endtask

  // Soft reset sampled at edge S behaves like a lock rise sampled at S-1
  task automatic soft_restart();
    @(negedge iCLK);
    iSOFT_RST = 1'b1;
    @(negedge iCLK);
    iSOFT_RST = 1'b0;
    iACK      = '0;
    e0        = edges - 1;
    check('0, "soft_next_edge");
  endtask

  function automatic int rand_ack();
    return int'($urandom_range(0, 20)) - 3;
  endfunction

  initial begin
    int kd;
    iRST = 1'b1; iLOCK = 1'b0; iSOFT_RST = 1'b0; iACK = '0;
    repeat (3) @(negedge iCLK);
    check('0, "reset");
    iRST = 1'b0;
    repeat (3) begin
      @(negedge iCLK);
      check('0, "wait_lock");
    end

    iLOCK = 1'b1;
    e0    = edges + 1;
    run_seq(3, 40, "nominal");

    soft_restart();
    run_seq(rand_ack(), 40, "soft_in_run");

    soft_restart();
    run_seq(999, 32, "timeout");
    iLOCK = 1'b0;
    run_seq(999, 38, "fault_lock_drop");
    iLOCK = 1'b1;
    run_seq(999, 42, "fault_relock");
    soft_restart();
    run_seq(rand_ack(), 45, "after_fault");

    soft_restart();
    run_seq(14, 40, "ack_timeout_tie");

    soft_restart();
    kd = 6 + int'($urandom_range(0, 3));
    run_seq(999, kd, "pre_lock_loss");
    iLOCK = 1'b0;
    @(negedge iCLK);
    check(model(kd + 1), "lock_loss_e1");
    @(negedge iCLK);
    check(model(kd + 2), "lock_loss_e2");
    repeat (4) begin
      @(negedge iCLK);
      check('0, "lock_loss_low");
    end
    iLOCK = 1'b1;
    e0    = edges + 1;
    run_seq(rand_ack(), 45, "relock");

    soft_restart();
    run_seq(999, 2 + D0 + D1 + 3, "pre_async_rst");
    iRST = 1'b1;
    #1;
    check('0, "async_rst_immediate");
    @(negedge iCLK);
    check('0, "async_rst_hold");
    iRST = 1'b0;
    iACK = '0;
    e0   = edges + 1;
    run_seq(rand_ack(), 45, "after_async_rst");

    repeat (6) begin
      soft_restart();
      run_seq(rand_ack(), 45, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", nchk);
    $fatal(1, "watchdog expired");
  end

endmodule
